// File: rtl/dac_frame_scheduler.sv
// rtl/dac_frame_scheduler.sv - DAC82002 serial port scheduler: init frame, config/sample arbitration, 24-bit serializer
module dac_frame_scheduler #(
    parameter int          CLK_DIV   = 4,
    parameter int          SYNC_GAP  = 4,
    parameter logic [23:0] INIT_WORD = 24'h06FFFF
) (
    input  logic        mck_i,
    input  logic        rst_i,
    input  logic        smp_l_valid_i,
    input  logic [23:0] smp_l_i,
    input  logic        smp_r_valid_i,
    input  logic [23:0] smp_r_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [7:0]  cfg_cmd_i,
    input  logic [15:0] cfg_data_i,
    input  logic        overrun_clr_i,
    output logic        sdo,
    output logic        sync,
    output logic        sclk,
    output logic        init_done_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {ST_GRANT, ST_SHIFT, ST_GAP, ST_IDLE} state_t;

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

    state_t        state_q, state_d;
    logic [23:0]   shreg_q, shreg_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          sdo_q, sdo_d;
    logic          sync_q, sync_d;
    logic          sclk_q, sclk_d;
    logic          init_pend_q, init_pend_d;
    logic          init_frame_q, init_frame_d;
    logic          init_done_q, init_done_d;
    logic          ovr_q, ovr_d;
    logic          l_pend_q, l_pend_d;
    logic          r_pend_q, r_pend_d;
    logic [15:0]   l_data_q, l_data_d;
    logic [15:0]   r_data_q, r_data_d;
    logic          last_cfg_q, last_cfg_d;
    logic          rr_right_q, rr_right_d;

    logic          in_grant;
    logic          smp_req;
    logic          pick_cfg;
    logic          pick_smp;
    logic          pick_right;
    logic          grant_l;
    logic          grant_r;
    logic          pending_any;
    logic          have_frame;
    logic [23:0]   frame_w;

    // Sample LSBs below the 16-bit DAC resolution are intentionally dropped.
    logic unused_lsbs;
    assign unused_lsbs = ^{smp_l_i[7:0], smp_r_i[7:0]};

    // Arbitration: init first, then class alternation on ties, then left/right round-robin.
    always_comb begin
        in_grant    = (state_q == ST_GRANT) && !rst_i;
        smp_req     = l_pend_q || r_pend_q;
        pick_cfg    = !init_pend_q && cfg_valid_i && (!smp_req || !last_cfg_q);
        pick_smp    = !init_pend_q && smp_req && !pick_cfg;
        pick_right  = r_pend_q && (!l_pend_q || rr_right_q);
        grant_l     = in_grant && pick_smp && !pick_right;
        grant_r     = in_grant && pick_smp && pick_right;
        pending_any = init_pend_q || cfg_valid_i || l_pend_q || r_pend_q
                      || smp_l_valid_i || smp_r_valid_i;
        cfg_ready_o = in_grant && pick_cfg;
    end

    // Sample slots and sticky overrun; a strobe in the grant cycle refills the slot without overrun.
    always_comb begin
        l_pend_d = l_pend_q;
        l_data_d = l_data_q;
        r_pend_d = r_pend_q;
        r_data_d = r_data_q;
        if (grant_l) l_pend_d = 1'b0;
        if (grant_r) r_pend_d = 1'b0;
        if (smp_l_valid_i) begin
            l_pend_d = 1'b1;
            l_data_d = {~smp_l_i[23], smp_l_i[22:8]};
        end
        if (smp_r_valid_i) begin
            r_pend_d = 1'b1;
            r_data_d = {~smp_r_i[23], smp_r_i[22:8]};
        end
        if ((smp_l_valid_i && l_pend_q && !grant_l) || (smp_r_valid_i && r_pend_q && !grant_r))
            ovr_d = 1'b1;
        else if (overrun_clr_i)
            ovr_d = 1'b0;
        else
            ovr_d = ovr_q;
    end

    // Frame FSM next-state and serializer outputs.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        sdo_d        = sdo_q;
        sync_d       = sync_q;
        sclk_d       = sclk_q;
        init_pend_d  = init_pend_q;
        init_frame_d = init_frame_q;
        init_done_d  = init_done_q;
        last_cfg_d   = last_cfg_q;
        rr_right_d   = rr_right_q;
        have_frame   = 1'b0;
        frame_w      = 24'h000000;
        case (state_q)
            ST_GRANT: begin
                if (init_pend_q) begin
                    have_frame   = 1'b1;
                    frame_w      = INIT_WORD;
                    init_pend_d  = 1'b0;
                    init_frame_d = 1'b1;
                end else if (pick_cfg) begin
                    have_frame   = 1'b1;
                    frame_w      = {cfg_cmd_i, cfg_data_i};
                    init_frame_d = 1'b0;
                    last_cfg_d   = 1'b1;
                end else if (pick_smp) begin
                    have_frame   = 1'b1;
                    frame_w      = pick_right ? {8'h09, r_data_q} : {8'h08, l_data_q};
                    init_frame_d = 1'b0;
                    last_cfg_d   = 1'b0;
                    rr_right_d   = !pick_right;
                end
                if (have_frame) begin
                    shreg_d   = frame_w;
                    sdo_d     = frame_w[23];
                    sync_d    = 1'b0;
                    sclk_d    = 1'b1;
                    bit_cnt_d = 5'd0;
                    div_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 5'd23) begin
                        sync_d    = 1'b1;
                        sdo_d     = 1'b0;
                        sclk_d    = 1'b0;
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                        if (init_frame_q) init_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shreg_d   = {shreg_q[22:0], 1'b0};
                        sdo_d     = shreg_q[22];
                        sclk_d    = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                    sclk_d    = (div_cnt_q + DW'(1)) < DIV_HALF;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST)
                    state_d = pending_any ? ST_GRANT : ST_IDLE;
                else
                    gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: begin
                if (pending_any) state_d = ST_GRANT;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge mck_i) begin
        if (rst_i) begin
            state_q      <= ST_GRANT;
            shreg_q      <= 24'h000000;
            bit_cnt_q    <= 5'd0;
            div_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            sdo_q        <= 1'b0;
            sync_q       <= 1'b1;
            sclk_q       <= 1'b0;
            init_pend_q  <= 1'b1;
            init_frame_q <= 1'b0;
            init_done_q  <= 1'b0;
            ovr_q        <= 1'b0;
            l_pend_q     <= 1'b0;
            r_pend_q     <= 1'b0;
            l_data_q     <= 16'h0000;
            r_data_q     <= 16'h0000;
            last_cfg_q   <= 1'b0;
            rr_right_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            sdo_q        <= sdo_d;
            sync_q       <= sync_d;
            sclk_q       <= sclk_d;
            init_pend_q  <= init_pend_d;
            init_frame_q <= init_frame_d;
            init_done_q  <= init_done_d;
            ovr_q        <= ovr_d;
            l_pend_q     <= l_pend_d;
            r_pend_q     <= r_pend_d;
            l_data_q     <= l_data_d;
            r_data_q     <= r_data_d;
            last_cfg_q   <= last_cfg_d;
            rr_right_q   <= rr_right_d;
        end
    end

    assign sdo         = sdo_q;
    assign sync        = sync_q;
    assign sclk        = sclk_q;
    assign init_done_o = init_done_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb/tb_dac_frame_scheduler.sv - self-checking bench for dac_frame_scheduler
module tb_dac_frame_scheduler;

    localparam int CLK_DIV   = 4;
    localparam int SYNC_GAP  = 4;
    localparam int FRAME_CYC = 24 * CLK_DIV;
    localparam int PERIOD    = 1 + FRAME_CYC + SYNC_GAP;
    localparam int NEVER     = 32'h1fffffff;

    logic        mck_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        smp_l_valid_i = 1'b0;
    logic [23:0] smp_l_i = 24'h0;
    logic        smp_r_valid_i = 1'b0;
    logic [23:0] smp_r_i = 24'h0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [7:0]  cfg_cmd_i = 8'h0;
    logic [15:0] cfg_data_i = 16'h0;
    logic        overrun_clr_i = 1'b0;
    logic        sdo, sync, sclk, init_done_o, overrun_o;

    dac_frame_scheduler #(
        .CLK_DIV(CLK_DIV), .SYNC_GAP(SYNC_GAP), .INIT_WORD(24'h06FFFF)
    ) dut (
        .mck_i(mck_i), .rst_i(rst_i),
        .smp_l_valid_i(smp_l_valid_i), .smp_l_i(smp_l_i),
        .smp_r_valid_i(smp_r_valid_i), .smp_r_i(smp_r_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_cmd_i(cfg_cmd_i), .cfg_data_i(cfg_data_i),
        .overrun_clr_i(overrun_clr_i),
        .sdo(sdo), .sync(sync), .sclk(sclk),
        .init_done_o(init_done_o), .overrun_o(overrun_o)
    );

    always #5 mck_i = ~mck_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge mck_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // Config request queue; the agent holds valid until the handshake completes.
    logic [23:0] cfg_q[$];
    bit          acc_seen = 0;
    always begin
        @(posedge mck_i);
        #1;
        if (acc_seen && cfg_q.size() > 0) void'(cfg_q.pop_front());
        if (cfg_q.size() > 0) begin
            cfg_valid_i = 1'b1;
            {cfg_cmd_i, cfg_data_i} = cfg_q[0];
        end else begin
            cfg_valid_i = 1'b0;
        end
    end

    // Reference model: grants happen at scheduled bus-free times, pins derived from frame offset.
    bit          m_on = 0;
    int          m_next, m_g, m_done_at;
    logic [23:0] m_word = 24'h0;
    bit          m_init_pend, m_req_prev, m_l_pend, m_r_pend, m_last_cfg, m_rr_right, m_ovr;
    logic [15:0] m_l = 16'h0, m_r = 16'h0;
    int          ready_cnt = 0;
    int          fall_cnt = 0;
    logic        sync_prev = 1'bx;

    always begin
        int  o;
        bit  inf, e_sclk, e_sdo, grant, g_cfg, g_l, g_r;
        @(negedge mck_i);
        acc_seen = cfg_valid_i && cfg_ready_o;
        if (cfg_ready_o === 1'b1) ready_cnt++;
        if (sync_prev === 1'b1 && sync === 1'b0) fall_cnt++;
        sync_prev = sync;
        grant = 0; g_cfg = 0; g_l = 0; g_r = 0;
        if (m_on) begin
            o      = cyc - m_g - 1;
            inf    = (o >= 0) && (o < FRAME_CYC);
            e_sclk = inf && ((o % CLK_DIV) < CLK_DIV / 2);
            e_sdo  = 0;
            if (inf) e_sdo = m_word[23 - o / CLK_DIV];
            grant  = !rst_i && (cyc >= m_next) && m_req_prev;
            if (grant && !m_init_pend) begin
                if (cfg_valid_i && (!(m_l_pend || m_r_pend) || !m_last_cfg)) g_cfg = 1;
                else if (m_l_pend && (!m_r_pend || !m_rr_right))             g_l = 1;
                else if (m_r_pend)                                          g_r = 1;
            end
            check("pins{sync,sclk,sdo,rdy,done,ovr}",
                  {26'd0, sync, sclk, sdo, cfg_ready_o, init_done_o, overrun_o},
                  {26'd0, !inf, e_sclk, e_sdo, g_cfg, (cyc >= m_done_at), m_ovr});
        end
        if (rst_i) begin
            m_on = 1; m_next = cyc + 1; m_g = -NEVER; m_done_at = NEVER;
            m_init_pend = 1; m_req_prev = 1; m_l_pend = 0; m_r_pend = 0;
            m_last_cfg = 0; m_rr_right = 0; m_ovr = 0;
        end else if (m_on) begin
            m_req_prev = m_init_pend | cfg_valid_i | m_l_pend | m_r_pend | smp_l_valid_i | smp_r_valid_i;
            if (grant && (m_init_pend || g_cfg || g_l || g_r)) begin
                m_g = cyc;
                m_next = cyc + PERIOD;
                if (m_init_pend) begin
                    m_word = 24'h06FFFF; m_init_pend = 0; m_done_at = cyc + 1 + FRAME_CYC;
                end else if (g_cfg) begin
                    m_word = {cfg_cmd_i, cfg_data_i}; m_last_cfg = 1;
                end else if (g_l) begin
                    m_word = {8'h08, m_l}; m_l_pend = 0; m_last_cfg = 0; m_rr_right = 1;
                end else begin
                    m_word = {8'h09, m_r}; m_r_pend = 0; m_last_cfg = 0; m_rr_right = 0;
                end
            end
            if (overrun_clr_i) m_ovr = 0;
            if (smp_l_valid_i) begin
                if (m_l_pend) m_ovr = 1;
                m_l_pend = 1;
                m_l = {~smp_l_i[23], smp_l_i[22:8]};
            end
            if (smp_r_valid_i) begin
                if (m_r_pend) m_ovr = 1;
                m_r_pend = 1;
                m_r = {~smp_r_i[23], smp_r_i[22:8]};
            end
        end
    end

    task automatic tick();
        @(posedge mck_i);
        #1;
    endtask

    task automatic strobe(input bit dl, input logic [23:0] vl, input bit dr, input logic [23:0] vr);
        smp_l_valid_i = dl; smp_l_i = vl;
        smp_r_valid_i = dr; smp_r_i = vr;
        tick();
        smp_l_valid_i = 1'b0;
        smp_r_valid_i = 1'b0;
    endtask

    task automatic wait_quiet();
        int n, t;
        n = 0; t = 0;
        while (n < 12 && t < 3000) begin
            tick();
            t++;
            if (sync === 1'b1 && cfg_q.size() == 0) n++;
            else n = 0;
        end
        check("bus_quiet", n, 12);
    endtask

    task automatic capture(output logic [23:0] w, output int fall, output int len, output int pulses);
        int   t;
        logic ps;
        w = 24'h0; fall = -1; len = 0; pulses = 0; t = 0; ps = 1'b0;
        @(negedge mck_i);
        while (sync !== 1'b0 && t < 2000) begin
            @(negedge mck_i);
            t++;
        end
        if (sync !== 1'b0) begin
            check("capture_timeout", {31'd0, sync}, 32'd0);
            return;
        end
        fall = cyc;
        while (sync === 1'b0 && len < 2000) begin
            len++;
            if (ps && !sclk) begin
                pulses++;
                w = {w[22:0], sdo};
            end
            ps = sclk;
            @(negedge mck_i);
        end
    endtask

    typedef struct {
        bit          right;
        logic [23:0] smp;
        logic [23:0] frame;
    } vec_t;

    vec_t        vecs[6];
    logic [23:0] w, w2, w3;
    int          f, f2, f3, l, p, r0, t0, rc0, fc;
    logic [23:0] exp5[5];

    initial begin
        vecs[0] = '{1'b0, 24'h123456, 24'h089234};
        vecs[1] = '{1'b1, 24'hFFFF00, 24'h097FFF};
        vecs[2] = '{1'b0, 24'h800000, 24'h080000};
        vecs[3] = '{1'b1, 24'h7FFFFF, 24'h09FFFF};
        vecs[4] = '{1'b0, 24'h000000, 24'h088000};
        vecs[5] = '{1'b1, 24'hFF8000, 24'h097F80};

        // Reset and power-up init frame
        rst_i = 1'b1;
        tick();
        @(negedge mck_i);
        check("reset_vals{sdo,sync,sclk,rdy,done,ovr}",
              {26'd0, sdo, sync, sclk, cfg_ready_o, init_done_o, overrun_o}, 32'b010000);
        tick(); tick();
        rst_i = 1'b0;
        r0 = cyc;
        capture(w, f, l, p);
        check("init_word", w, 24'h06FFFF);
        check("init_fall", f - r0, 1);
        check("init_len", l, FRAME_CYC);
        check("init_pulses", p, 24);
        check("init_done_cyc", cyc - r0, 97);
        check("init_done", init_done_o, 1);
        check("init_no_ready", ready_cnt, 0);

        // Table of single samples from an idle bus
        foreach (vecs[i]) begin
            wait_quiet();
            t0 = cyc;
            strobe(!vecs[i].right, vecs[i].smp, vecs[i].right, vecs[i].smp);
            capture(w, f, l, p);
            check("vec_word", w, vecs[i].frame);
            check("vec_latency", f - t0, 2);
            check("vec_len", l, FRAME_CYC);
        end

        // Config + both samples pending: config wins the tie, then left, then right
        wait_quiet();
        @(negedge mck_i);
        cfg_q.push_back(24'h020003);
        rc0 = ready_cnt;
        tick();
        t0 = cyc;
        strobe(1, 24'h400000, 1, 24'hC00000);
        capture(w, f, l, p);
        capture(w2, f2, l, p);
        capture(w3, f3, l, p);
        check("prio_first", w, 24'h020003);
        check("prio_second", w2, 24'h08C000);
        check("prio_third", w3, 24'h094000);
        check("prio_latency", f - t0, 2);
        check("spacing_12", f2 - f, PERIOD);
        check("spacing_23", f3 - f2, PERIOD);
        check("ready_once", ready_cnt - rc0, 1);

        // Left overwritten while a config frame is in flight
        wait_quiet();
        @(negedge mck_i);
        cfg_q.push_back(24'h03ABCD);
        tick(); tick(); tick();
        strobe(1, 24'h100000, 0, 24'h0);
        repeat (5) tick();
        strobe(1, 24'h200000, 0, 24'h0);
        @(negedge mck_i);
        check("overrun_set", overrun_o, 1);
        for (int i = 0; i < 200 && sync !== 1'b1; i++) tick();
        capture(w, f, l, p);
        check("overrun_word", w, 24'h08A000);
        fc = fall_cnt;
        repeat (150) tick();
        check("overrun_single_frame", fall_cnt, fc);
        check("overrun_sticky", overrun_o, 1);
        overrun_clr_i = 1'b1;
        tick();
        overrun_clr_i = 1'b0;
        @(negedge mck_i);
        check("overrun_cleared", overrun_o, 0);

        // Continuous config traffic plus one right sample
        wait_quiet();
        @(negedge mck_i);
        cfg_q.push_back(24'h040001);
        cfg_q.push_back(24'h040002);
        cfg_q.push_back(24'h040003);
        cfg_q.push_back(24'h040004);
        exp5[0] = 24'h040001; exp5[1] = 24'h09E543; exp5[2] = 24'h040002;
        exp5[3] = 24'h040003; exp5[4] = 24'h040004;
        tick();
        strobe(0, 24'h0, 1, 24'h654321);
        for (int i = 0; i < 5; i++) begin
            capture(w, f, l, p);
            check("alt_frame", w, exp5[i]);
        end

        // Reset at bit 10 of a sample frame
        wait_quiet();
        t0 = cyc;
        strobe(1, 24'h0F0F0F, 0, 24'h0);
        while (cyc < t0 + 2 + 10 * CLK_DIV) tick();
        check("midframe_sync_low", {31'd0, sync}, 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        r0 = cyc;
        @(negedge mck_i);
        check("abort_vals{sync,sclk,sdo,done}", {28'd0, sync, sclk, sdo, init_done_o}, 32'b1000);
        capture(w, f, l, p);
        check("reinit_word", w, 24'h06FFFF);
        check("reinit_fall", f - r0, 1);
        check("reinit_len", l, FRAME_CYC);

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            if (cfg_q.size() == 0 && $urandom_range(0, 119) == 0) cfg_q.push_back(24'($urandom));
            overrun_clr_i = ($urandom_range(0, 79) == 0);
            smp_l_valid_i = ($urandom_range(0, 49) == 0);
            smp_l_i       = 24'($urandom);
            smp_r_valid_i = ($urandom_range(0, 49) == 0);
            smp_r_i       = 24'($urandom);
            tick();
        end
        smp_l_valid_i = 1'b0;
        smp_r_valid_i = 1'b0;
        overrun_clr_i = 1'b0;
        repeat (400) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_frame_scheduler.md
# dac_frame_scheduler

Single-clock scheduler and serializer that owns the DAC82002 serial port (sdo/sync/sclk). It issues a power-up configuration frame after reset, then arbitrates between left/right audio sample slots and a host configuration port, converting each winner into a 24-bit frame {cmd[7:0], data[15:0]}. It sits between the I2S sample capture logic and the DAC pins, so sample and register traffic never collide on the bus.

## Interface
- CLK_DIV, 4: mck_i cycles per sclk period; even, ≥2.
- SYNC_GAP, 4: minimum mck_i cycles sync is held high between frames; ≥1.
- INIT_WORD, 24'h06FFFF: frame sent once after reset.
- mck_i  in  1  clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- smp_l_valid_i  in  1  one-cycle strobe; left sample on smp_l_i.
- smp_l_i  in  24  left sample, two's complement.
- smp_r_valid_i  in  1  one-cycle strobe; right sample on smp_r_i.
- smp_r_i  in  24  right sample, two's complement.
- cfg_valid_i  in  1  config request; hold until accepted.
- cfg_ready_o  out  1  config accepted when valid & ready.
- cfg_cmd_i  in  8  config command byte.
- cfg_data_i  in  16  config data.
- overrun_clr_i  in  1  clears overrun_o.
- sdo  out  1  serial data, MSB first.
- sync  out  1  frame select, active-low.
- sclk  out  1  serial clock; DAC samples sdo on falling edge.
- init_done_o  out  1  high once INIT_WORD has been fully shifted.
- overrun_o  out  1  sticky: sample overwritten before it was sent.

## Operation
- Reset values: sdo=0, sync=1, sclk=0, cfg_ready_o=0, init_done_o=0, overrun_o=0. Both sample slots empty, init pending, state GRANT.
- Sample slots: one-deep register per channel. On a strobe the slot loads data {~s[23], s[22:8]} (offset binary, top 16 bits) and is marked pending. Command is 8'h08 for left, 8'h09 for right.
- A strobe on a slot that is already pending overwrites that slot and sets overrun_o. overrun_o stays set until overrun_clr_i. If set and clear occur in the same cycle, set wins.
- States:
  - GRANT: select the winner, load the 24-bit shift register, go to SHIFT.
  - SHIFT: send 24 bits, then go to GAP.
  - GAP: hold sync high for SYNC_GAP cycles, then go to GRANT if any request is pending, else IDLE.
  - IDLE: go to GRANT on any pending request.
- Priority in GRANT:
  - Init pending always wins.
  - Between classes (config vs. sample), when both are pending, the class not granted last wins. After reset the last-granted class is "sample", so config wins the first tie.
  - Within samples: left/right round-robin, left first after reset.
- cfg_ready_o is a one-cycle pulse, asserted only in the GRANT cycle in which config wins. It is never asserted while init is pending.
- A sample strobe arriving in the same cycle the slot is granted: the grant takes the old value, and the new value stays pending with no overrun.

## Timing
- GRANT lasts 1 cycle. sync falls on the cycle after GRANT, with sdo = frame bit 23.
- Bit n, MSB first, occupies CLK_DIV cycles with sdo stable. sclk is high for the first CLK_DIV/2 cycles and low for the second half, so the falling edge is mid-bit.
- sync rises on the cycle after the last bit's period, together with sdo=0 and sclk=0. SHIFT lasts exactly 24*CLK_DIV cycles.
- Frame-to-frame spacing under continuous load: 1 + 24*CLK_DIV + SYNC_GAP cycles.
- Latency from an idle bus: strobe at cycle t loads the slot; GRANT at t+1; sync low at t+2.
- init_done_o rises in the same cycle sync rises after the init frame.
- rst_i asserted mid-frame aborts it immediately: the next cycle shows reset values, and the init frame is resent.

## Test plan
- Reset, CLK_DIV=4, SYNC_GAP=4 -> sync low 96 cycles shifting 0x06FFFF, sclk 24 pulses, init_done_o=1 at cycle 97 after reset release; cfg_ready_o stays 0 throughout.
- After init, left strobe 24'h123456 -> frame 0x089234; right strobe 24'hFFFF00 -> frame 0x097FFF; sync falls 2 cycles after the strobe when the bus is idle.
- cfg_valid_i held with cmd 0x02 / data 0x0003 and both sample slots pending -> order config, left, right; cfg_ready_o pulses once; spacing between frames 101 cycles.
- Left strobed twice (0x100000, then 0x200000) while a frame is in flight -> one left frame with data 0xA000, overrun_o=1; overrun_clr_i -> 0.
- Continuous config requests plus a right sample -> frames alternate config/sample; the sample is sent within 2 frames.
- rst_i at bit 10 of a sample frame -> next cycle sync=1, sclk=0, sdo=0, init_done_o=0; init frame restarts 1 cycle after reset release.
